// File: rtl/dmem_pkg.sv
// Shared encodings and the fixed preload table for the data memory controller.
package dmem_pkg;

   localparam logic SZ_BYTE = 1'b0;
   localparam logic SZ_WORD = 1'b1;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_BUSY,
      ST_RESP
   } dmem_state_t;

   localparam int PRELOAD_N = 5;

   // Word-aligned byte addresses and the little-endian words written there after the clear sweep
   localparam logic [15:0] PRELOAD_ADDR [PRELOAD_N] = '{16'h0000, 16'h0002, 16'h0004, 16'h0006, 16'h0008};
   localparam logic [15:0] PRELOAD_DATA [PRELOAD_N] = '{16'h3856, 16'h0000, 16'h4312, 16'hBEDE, 16'hADEF};

endpackage

// File: rtl/dmem_init_seq.sv
// Post-reset init sequencer: clears every byte pair, then walks the preload table.
module dmem_init_seq
   import dmem_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int DEPTH_BYTES = 1024,
   parameter int PRELOAD_EN  = 1,
   localparam int IDX_W      = $clog2(DEPTH_BYTES)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   output logic              init_we,
   output logic [IDX_W-1:0]  init_addr,
   output logic [DATA_W-1:0] init_data,
   output logic              init_last
);

   localparam int CLEAR_N = DEPTH_BYTES / 2;
   localparam int TOTAL   = CLEAR_N + ((PRELOAD_EN != 0) ? PRELOAD_N : 0);
   localparam int CNT_W   = $clog2(CLEAR_N + PRELOAD_N + 1);

   logic [CNT_W-1:0] sweep;
   logic [2:0]       pidx;

   // Sweep counter: one step per init cycle, restarts from zero on reset
   always_ff @(posedge clk) begin
      if (reset) begin
         sweep <= '0;
      end else if (en) begin
         sweep <= sweep + CNT_W'(1);
      end
   end

   // Clear phase writes zero to pair {2k, 2k+1}; the tail of the sweep indexes the preload table
   always_comb begin
      init_we   = en;
      init_addr = '0;
      init_data = '0;
      pidx      = 3'(sweep - CNT_W'(CLEAR_N));
      if (sweep < CNT_W'(CLEAR_N)) begin
         init_addr = IDX_W'({sweep, 1'b0});
      end else if (pidx < 3'(PRELOAD_N)) begin
         init_addr = IDX_W'(PRELOAD_ADDR[pidx]);
         init_data = DATA_W'(PRELOAD_DATA[pidx]);
      end
      init_last = en && (sweep == CNT_W'(TOTAL - 1));
   end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory for the MEM stage: valid/ready requests, fixed response latency.
module data_memory_ctrl
   import dmem_pkg::*;
#(
   parameter int DATA_W         = 16,
   parameter int DEPTH_BYTES    = 1024,
   parameter int ADDR_W         = 16,
   parameter int RESP_LAT       = 1,
   parameter int ALLOW_MISALIGN = 0,
   parameter int PRELOAD_EN     = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              init_done
);

   localparam int IDX_W = $clog2(DEPTH_BYTES);
   localparam int LAT_W = (RESP_LAT > 2) ? $clog2(RESP_LAT) : 1;

   dmem_state_t       state, state_next;
   logic [LAT_W-1:0]  lat_cnt, lat_next;
   logic              accept;
   logic              req_bad;
   logic [IDX_W-1:0]  idx, idx1;
   logic [7:0]        byte_lo;
   logic [DATA_W-1:0] load_data, hold_data;
   logic              hold_err;
   logic              init_en, init_we, init_last;
   logic [IDX_W-1:0]  init_addr;
   logic [DATA_W-1:0] init_data;
   logic [7:0]        mem [DEPTH_BYTES];

   assign init_en = (state == ST_INIT) && !reset;

   dmem_init_seq #(
      .DATA_W      (DATA_W),
      .DEPTH_BYTES (DEPTH_BYTES),
      .PRELOAD_EN  (PRELOAD_EN)
   ) u_init (
      .clk       (clk),
      .reset     (reset),
      .en        (init_en),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_data (init_data),
      .init_last (init_last)
   );

   // Request decode: range/alignment check and the load result as seen before this edge's write
   always_comb begin
      idx     = req_addr[IDX_W-1:0];
      idx1    = idx + IDX_W'(1);
      req_bad = ({1'b0, req_addr} >= (ADDR_W+1)'(DEPTH_BYTES))
             || ((req_size == SZ_WORD) && (req_addr == ADDR_W'(DEPTH_BYTES - 1)))
             || ((req_size == SZ_WORD) && req_addr[0] && (ALLOW_MISALIGN == 0));
      byte_lo   = mem[idx];
      load_data = '0;
      if (!req_bad && !req_write) begin
         if (req_size == SZ_WORD) begin
            load_data = {mem[idx1], byte_lo};
         end else begin
            load_data = {{(DATA_W-8){req_signed & byte_lo[7]}}, byte_lo};
         end
      end
   end

   // Array writes: init sweep owns the array during INIT, accepted good stores afterwards
   always_ff @(posedge clk) begin
      if (init_we) begin
         mem[init_addr]                       <= init_data[7:0];
         mem[{init_addr[IDX_W-1:1], 1'b1}]    <= init_data[15:8];
      end else if (accept && req_write && !req_bad) begin
         mem[idx] <= req_wdata[7:0];
         if (req_size == SZ_WORD) begin
            mem[idx1] <= req_wdata[15:8];
         end
      end
   end

   // Holding register captures the response contents at acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         hold_data <= load_data;
         hold_err  <= req_bad;
      end
   end

   // Control state: FSM, latency countdown, sticky init_done
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_INIT;
         lat_cnt   <= '0;
         init_done <= 1'b0;
      end else begin
         state   <= state_next;
         lat_cnt <= lat_next;
         if (init_last) begin
            init_done <= 1'b1;
         end
      end
   end

   // Next state, ready and acceptance; RESP may accept a follow-on request in the same cycle
   always_comb begin
      state_next = state;
      lat_next   = lat_cnt;
      req_ready  = 1'b0;
      case (state)
         ST_INIT: if (init_last) state_next = ST_IDLE;
         ST_IDLE: req_ready = 1'b1;
         ST_BUSY: begin
            if (lat_cnt == '0) state_next = ST_RESP;
            else               lat_next   = lat_cnt - LAT_W'(1);
         end
         ST_RESP: begin
            req_ready  = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_INIT;
      endcase
      accept = req_valid && req_ready && !reset;
      if (accept) begin
         if (RESP_LAT == 1) begin
            state_next = ST_RESP;
         end else begin
            state_next = ST_BUSY;
            lat_next   = LAT_W'(RESP_LAT - 2);
         end
      end
   end

   assign rsp_valid = (state == ST_RESP);
   assign rsp_rdata = rsp_valid ? hold_data : '0;
   assign rsp_err   = rsp_valid && hold_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench: two instances (RESP_LAT 1 and 3) checked against a byte-array reference model.
module tb_data_memory_ctrl;
   import dmem_pkg::*;

   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]       rst, req_valid, req_ready, req_write, req_size, req_signed;
   logic [1:0]       rsp_valid, rsp_err, init_done;
   logic [1:0][15:0] req_addr, req_wdata, rsp_rdata;

   for (genvar g = 0; g < 2; g++) begin : gen_u
      data_memory_ctrl #(.RESP_LAT((g == 0) ? 1 : 3)) dut (
         .clk        (clk),
         .reset      (rst[g]),
         .req_valid  (req_valid[g]),
         .req_ready  (req_ready[g]),
         .req_write  (req_write[g]),
         .req_size   (req_size[g]),
         .req_signed (req_signed[g]),
         .req_addr   (req_addr[g]),
         .req_wdata  (req_wdata[g]),
         .rsp_valid  (rsp_valid[g]),
         .rsp_rdata  (rsp_rdata[g]),
         .rsp_err    (rsp_err[g]),
         .init_done  (init_done[g])
      );
   end

   int n_checks = 0;
   int n_pass   = 0;
   int lat_of [2] = '{1, 3};
   logic [7:0] mdl [2][DEPTH];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
   endtask

   task automatic model_init(input int u);
      for (int i = 0; i < DEPTH; i++) mdl[u][i] = 8'h00;
      mdl[u][0] = 8'h56; mdl[u][1] = 8'h38;
      mdl[u][4] = 8'h12; mdl[u][5] = 8'h43;
      mdl[u][6] = 8'hDE; mdl[u][7] = 8'hBE;
      mdl[u][8] = 8'hEF; mdl[u][9] = 8'hAD;
   endtask

   task automatic model_txn(input int u, input bit w, input bit sz, input bit sg, input int addr,
                            input logic [15:0] wd, output logic [15:0] rd, output bit er);
      bit bad;
      bad = (addr >= DEPTH) || (sz && addr == DEPTH - 1) || (sz && (addr % 2 == 1));
      rd = 16'h0000;
      er = bad;
      if (!bad) begin
         if (w) begin
            mdl[u][addr] = wd[7:0];
            if (sz) mdl[u][addr + 1] = wd[15:8];
         end else if (sz) begin
            rd = 16'(int'(mdl[u][addr]) + 256 * int'(mdl[u][addr + 1]));
         end else begin
            rd = 16'(int'(mdl[u][addr]));
            if (sg && mdl[u][addr] >= 8'd128) rd = rd + 16'hFF00;
         end
      end
   endtask

   task automatic run_txn(input int u, input bit w, input bit sz, input bit sg, input int addr,
                          input logic [15:0] wd, input bit use_exp, input logic [15:0] exp_rd,
                          input bit exp_er, input string tag);
      logic [15:0] m_rd;
      bit m_er;
      int waited, lat;
      model_txn(u, w, sz, sg, addr, wd, m_rd, m_er);
      if (use_exp) begin
         m_rd = exp_rd;
         m_er = exp_er;
      end
      @(negedge clk);
      req_write[u] = w; req_size[u] = sz; req_signed[u] = sg;
      req_addr[u] = 16'(addr); req_wdata[u] = wd; req_valid[u] = 1'b1;
      waited = 0;
      while (!req_ready[u] && waited < 1000) begin
         @(negedge clk);
         waited++;
      end
      if (!req_ready[u]) begin
         check({tag, "_ready_timeout"}, 0, 1);
         req_valid[u] = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid[u] = 1'b0;
      lat = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (rsp_valid[u]) break;
      end
      check({tag, "_lat"}, lat, lat_of[u]);
      check({tag, "_rdata"}, rsp_rdata[u], m_rd);
      check({tag, "_err"}, rsp_err[u], m_er);
   endtask

   task automatic wait_init(input int u, output int cyc, output int bad);
      cyc = 0;
      bad = 0;
      while (!init_done[u] && cyc < 600) begin
         @(negedge clk);
         if (req_ready[u] || rsp_valid[u]) bad++;
         @(posedge clk);
         #1 cyc++;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int cyc, bad, w, addr, r;
      logic rv;

      rst = 2'b11; req_valid = 2'b11; req_write = '0; req_size = '0; req_signed = '0;
      req_addr = '0; req_wdata = '0;
      @(posedge clk);
      #1;
      check("rst_ready", req_ready[0], 0);
      check("rst_rsp_valid", rsp_valid[0], 0);
      check("rst_rdata", rsp_rdata[0], 0);
      check("rst_err", rsp_err[0], 0);
      check("rst_init_done", init_done[0], 0);
      rst = 2'b00;
      wait_init(0, cyc, bad);
      req_valid = 2'b00;
      check("init_cycles", cyc, 517);
      check("init_quiet", bad, 0);
      check("init_done_u1", init_done[1], 1);
      model_init(0);
      model_init(1);

      run_txn(0, 0, 1, 0, 16'h0006, 0, 1, 16'hBEDE, 0, "ld_w6");
      run_txn(0, 0, 0, 0, 16'h0006, 0, 1, 16'h00DE, 0, "ld_bu6");
      run_txn(0, 0, 0, 1, 16'h0006, 0, 1, 16'hFFDE, 0, "ld_bs6");
      run_txn(0, 0, 0, 1, 16'h0009, 0, 1, 16'hFFAD, 0, "ld_bs9");
      run_txn(0, 1, 1, 0, 16'h0010, 16'h1234, 1, 16'h0000, 0, "st_w10");
      run_txn(0, 0, 1, 0, 16'h0010, 0, 1, 16'h1234, 0, "ld_w10");
      run_txn(0, 1, 0, 0, 16'h0011, 16'h00AB, 1, 16'h0000, 0, "st_b11");
      run_txn(0, 0, 1, 0, 16'h0010, 0, 1, 16'hAB34, 0, "ld_w10b");
      run_txn(0, 0, 1, 0, 16'h0003, 0, 1, 16'h0000, 1, "misalign");
      run_txn(0, 1, 0, 0, DEPTH - 1, 16'h005A, 1, 16'h0000, 0, "st_b_last");
      run_txn(0, 1, 1, 0, DEPTH - 1, 16'hFFFF, 1, 16'h0000, 1, "st_w_last");
      run_txn(0, 0, 0, 0, DEPTH - 1, 0, 1, 16'h005A, 0, "ld_b_last");
      run_txn(0, 0, 0, 0, 0, 0, 1, 16'h0056, 0, "ld_b0_nowrap");
      run_txn(0, 0, 1, 0, DEPTH - 2, 0, 1, 16'h5A00, 0, "ld_w_edge");
      run_txn(0, 0, 0, 0, DEPTH, 0, 1, 16'h0000, 1, "ld_b_oor");

      run_txn(1, 0, 1, 0, 16'h0006, 0, 1, 16'hBEDE, 0, "lat3_ld_w6");

      // Back-to-back on the RESP_LAT=3 instance: A = word @6, B = word @0
      @(negedge clk);
      req_write[1] = 0; req_size[1] = 1; req_signed[1] = 0; req_addr[1] = 16'h0006; req_valid[1] = 1;
      w = 0;
      while (!req_ready[1] && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 req_addr[1] = 16'h0000;
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         case (c)
            1, 2: begin
               check("b2b_ready_low", req_ready[1], 0);
               check("b2b_rsp_early", rsp_valid[1], 0);
            end
            3: begin
               check("b2b_rsp_a", rsp_valid[1], 1);
               check("b2b_rdata_a", rsp_rdata[1], 16'hBEDE);
               check("b2b_ready_resp", req_ready[1], 1);
               @(posedge clk);
               #1 req_valid[1] = 0;
            end
            4: begin
               check("b2b_gap_valid", rsp_valid[1], 0);
               check("b2b_gap_rdata", rsp_rdata[1], 0);
            end
            5: check("b2b_gap_valid2", rsp_valid[1], 0);
            default: begin
               check("b2b_rsp_b", rsp_valid[1], 1);
               check("b2b_rdata_b", rsp_rdata[1], 16'h3856);
            end
         endcase
      end
      @(negedge clk);

      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = $urandom_range(0, DEPTH - 1);
            else if (r == 7) addr = $urandom_range(DEPTH - 4, DEPTH + 6);
            else if (r == 8) addr = $urandom_range(0, 15);
            else             addr = $urandom_range(0, 65535);
            run_txn(u, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    addr, 16'($urandom), 0, 16'h0000, 0, "rnd");
         end
      end

      // Reset while a RESP_LAT=3 load is in flight
      run_txn(1, 1, 1, 0, 16'h0010, 16'h1234, 1, 16'h0000, 0, "pre_rst_st");
      @(negedge clk);
      req_write[1] = 0; req_size[1] = 1; req_addr[1] = 16'h0010; req_valid[1] = 1;
      w = 0;
      while (!req_ready[1] && w < 50) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1;
      req_valid[1] = 0;
      rst[1] = 1;
      @(negedge clk);
      rv = rsp_valid[1];
      @(posedge clk);
      #1 rst[1] = 0;
      check("mid_rst_init_done", init_done[1], 0);
      req_valid[1] = 1;
      wait_init(1, cyc, bad);
      req_valid[1] = 0;
      check("mid_rst_no_rsp", rv, 0);
      check("reinit_cycles", cyc, 517);
      check("reinit_quiet", bad, 0);
      model_init(1);
      run_txn(1, 0, 1, 0, 16'h0010, 0, 1, 16'h0000, 0, "post_rst_ld10");
      run_txn(1, 0, 1, 0, 16'h0008, 0, 1, 16'hADEF, 0, "post_rst_ld8");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Parametrised byte-addressed data memory with valid/ready request handshake, configurable response latency, byte/word access with signed or unsigned byte loads, and range/alignment error reporting.
- After reset, a self-timed init sequence clears the array and optionally preloads a fixed word table before accepting requests.
- Sits on the MEM stage of the CPU datapath, serving lw/sw/lb/lbu/sb.

Parameters:
- DATA_W, 16, word width in bits; must be 16 (two bytes per word).
- DEPTH_BYTES, 1024, array size in bytes; power of two, >= 16.
- ADDR_W, 16, request byte-address width.
- RESP_LAT, 1, cycles from request acceptance to rsp_valid; >= 1.
- ALLOW_MISALIGN, 0, 1 permits word access at odd addresses.
- PRELOAD_EN, 1, 1 loads the package preload table after clearing.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  1  0 = byte, 1 = word.
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  one-cycle response pulse, for loads and stores.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: access rejected.
- init_done  out  1  high once init completes; stays high until reset.

Behaviour:
- Reset: reset is synchronous and active-high.
  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0; FSM enters INIT with the sweep counter at 0.
  - Reset mid-transaction abandons it: no rsp_valid is issued and init restarts.
- FSM states: INIT, IDLE, BUSY, RESP.
- INIT, clear phase:
  - Each cycle writes 0x00 to byte pair {2k, 2k+1}, where k is the sweep count.
  - Takes DEPTH_BYTES/2 cycles.
- INIT, preload phase (if PRELOAD_EN): one table entry per cycle, little-endian:
  - 0x0000 <- 0x3856
  - 0x0002 <- 0x0000
  - 0x0004 <- 0x4312
  - 0x0006 <- 0xBEDE
  - 0x0008 <- 0xADEF
  - Default init time: 512 + 5 = 517 cycles.
- INIT exit: go to IDLE and set init_done in the same cycle. req_valid is ignored throughout INIT.
- req_ready = 1 in IDLE and RESP only. Acceptance = req_valid & req_ready at a rising edge. At most one transaction is outstanding.
- At the acceptance edge:
  - Stores commit to the array.
  - Loads sample the array into a holding register, so a load accepted after a store always sees the store.
- Byte store: mem[a] <= wdata[7:0].
- Word store: mem[a] <= wdata[7:0] and mem[a+1] <= wdata[15:8] in the same edge.
- Byte load: rdata = {8{signed & b[7]}, b} for byte b.
- Word load: rdata = {mem[a+1], mem[a]}.
- Error conditions:
  - a >= DEPTH_BYTES.
  - Word access with a == DEPTH_BYTES-1 (no wrap-around).
  - Word access with a[0]=1 when ALLOW_MISALIGN=0.
  - On error: no array write, rsp_rdata=0, rsp_err=1 with rsp_valid.
- Latency:
  - RESP_LAT=1: acceptance -> RESP.
  - RESP_LAT>1: acceptance -> BUSY for RESP_LAT-1 cycles -> RESP.
  - rsp_valid, rsp_rdata and rsp_err are valid only while in RESP; rsp_valid is 0 elsewhere.
  - rsp_rdata and rsp_err return to 0 when rsp_valid falls.
- In RESP, a new request may be accepted in the same cycle (back-to-back).
  - One response per RESP_LAT cycles at steady state.
  - Without a new request, RESP -> IDLE.
- Simultaneous reset and req_valid: reset wins; the request is not accepted.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_WORD;
  - state enum dmem_state_t;
  - PRELOAD_N = 5;
  - preload address/data constant arrays.
- One sub-module, dmem_init_seq: sweep counter plus preload index.
  - Outputs init write enable, address and data, and init_last.
  - The top FSM muxes init writes against request writes.

Test Plan:
- Init and preload: reset 1 cycle, then hold req_valid=1 -> req_ready=0 and no response for 517 cycles; init_done=1 on cycle 517. Word load 0x0006 -> rsp_rdata=0xBEDE.
- Byte loads: load 0x0006 unsigned -> 0x00DE; signed -> 0xFFDE; load 0x0009 signed -> 0xFFAD.
- Store then load, RESP_LAT=1: word store 0x1234 @0x0010, next cycle word load 0x0010 -> 0x1234. Byte store 0xAB @0x0011, then word load -> 0xAB34.
- Latency with RESP_LAT=3:
  - Accept at cycle T -> rsp_valid exactly at T+3.
  - req_ready low at T+1 and T+2.
  - A back-to-back request accepted at T+3 responds at T+6.
- Errors:
  - Word load @0x0003 with ALLOW_MISALIGN=0 -> rsp_err=1, rdata=0.
  - Word store @DEPTH_BYTES-1 -> rsp_err=1 and the array is unchanged.
  - Byte load @DEPTH_BYTES -> rsp_err=1.
- Reset mid-operation: RESP_LAT=3, reset asserted at T+1 -> no rsp_valid, init_done=0, init reruns, and the previously stored 0x1234 @0x0010 reads back 0x0000.
